dbus_sram_responder: RTL and testbench

- Responder end of the data-bus request/response interface driven by the memory stage.
- Accepts one load/store request at a time through the `dreq`/`dresp` handshake.
- Models a word-organised SRAM with configurable response latency and byte-strobe writes.
- Serves as the simulation/FPGA data-memory target behind the memory stage. It also acts as the reference responder for exercising stall logic.

---
 rtl/dbus_sram_responder_if.sv | 21 ++
 rtl/dbus_sram_responder.sv | 105 ++++++++++
 tb/tb_dbus_sram_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_sram_responder_if.sv
// rtl/dbus_sram_responder_if.sv - data-bus request/response signal bundle
interface dbus_sram_responder_if;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - word SRAM responder with fixed latency and byte-strobe writes
module dbus_sram_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_sram_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [3:0]             strb_q;
    logic [31:0]            wdata_q;
    logic                   data_ok_q;
    logic [31:0]            rdata_q;

    logic [31:0]            mem [DEPTH];

    logic                   accept;
    logic [ADDR_BITS-1:0]   req_idx;

    // Size code and bits outside the word index do not affect the access.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.dreq_size, bus.dreq_addr[31:ADDR_BITS+2],
                           bus.dreq_addr[1:0]};

    assign req_idx            = bus.dreq_addr[ADDR_BITS+1:2];
    assign accept             = (state_q == IDLE) && bus.dreq_valid && !reset;
    assign bus.dresp_addr_ok  = accept;
    assign bus.dresp_data_ok  = data_ok_q;
    assign bus.dresp_data     = rdata_q;

    // Transaction sequencer: latch request, count latency, present read data in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            strb_q    <= 4'd0;
            wdata_q   <= 32'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_ok_q <= 1'b0;
                    if (bus.dreq_valid) begin
                        idx_q   <= req_idx;
                        strb_q  <= bus.dreq_strobe;
                        wdata_q <= bus.dreq_data;
                        cnt_q   <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q   <= RESP;
                            data_ok_q <= 1'b1;
                            rdata_q   <= mem[req_idx];
                        end else begin
                            state_q   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q     <= 4'd0;
                        state_q   <= RESP;
                        data_ok_q <= 1'b1;
                        // Only one request is ever in flight, so the array holds the old word here.
                        rdata_q   <= mem[idx_q];
                    end else begin
                        cnt_q     <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    data_ok_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    data_ok_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane write at the edge that closes RESP; a reset in RESP cancels it.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    a_ok_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(bus.dresp_addr_ok && bus.dresp_data_ok));

    a_data_ok_in_resp: assert property (@(posedge clk) disable iff (reset)
        bus.dresp_data_ok |-> (state_q == RESP));
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - self-checking bench for dbus_sram_responder
module tb_dbus_sram_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dbus_sram_responder_if b2 ();
    dbus_sram_responder_if b3 ();

    dbus_sram_responder #(.ADDR_BITS(12), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave)
    );
    dbus_sram_responder #(.ADDR_BITS(12), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(b3.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m2 [int];
    logic [31:0] m3 [int];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd4096);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic txn2(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd);
        int i, got, k;
        bit known;
        logic [31:0] exp;
        i = idx_of(a);
        known = m2.exists(i);
        exp = known ? m2[i] : 32'h0;
        got = -1;
        rd = 32'h0;
        @(posedge clk); #1;
        b2.dreq_valid = 1'b1; b2.dreq_addr = a; b2.dreq_strobe = s;
        b2.dreq_data = d; b2.dreq_size = 3'd2;
        @(negedge clk);
        checks++;
        if (b2.dresp_addr_ok !== 1'b1) begin
            errors++; $display("FAIL txn_addr_ok: got %b expected 1", b2.dresp_addr_ok);
        end
        @(posedge clk); #1;
        b2.dreq_valid = 1'b0; b2.dreq_addr = $urandom; b2.dreq_strobe = 4'($urandom);
        b2.dreq_data = $urandom;
        k = 0;
        while (got < 0 && k < 8) begin
            @(negedge clk);
            k++;
            checks++;
            if (b2.dresp_addr_ok !== 1'b0) begin
                errors++; $display("FAIL txn_busy_addr_ok: got %b expected 0 (cycle %0d)", b2.dresp_addr_ok, k);
            end
            if (b2.dresp_data_ok === 1'b1) begin
                got = k; rd = b2.dresp_data;
            end
        end
        checks++;
        if (got != 2) begin
            errors++; $display("FAIL txn_latency: got %0d expected 2", got);
        end
        if (known) begin
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL txn_data addr=%h: got %h expected %h", a, rd, exp);
            end
        end
        if (s == 4'hF) m2[i] = d;
        else if (known) m2[i] = merge(exp, d, s);
    endtask

    task automatic test_reset;
        int got, k;
        b2.dreq_valid = 1'b1; b2.dreq_addr = 32'h40; b2.dreq_strobe = 4'hF;
        b2.dreq_data = 32'hA5A5_0001; b2.dreq_size = 3'd2;
        b3.dreq_valid = 1'b1; b3.dreq_addr = 32'h80; b3.dreq_strobe = 4'h0;
        b3.dreq_data = 32'h0; b3.dreq_size = 3'd2;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({b2.dresp_addr_ok, b3.dresp_addr_ok, b2.dresp_data_ok, b3.dresp_data_ok} !== 4'b0) begin
                errors++; $display("FAIL reset_ok: got %b%b%b%b expected 0000", b2.dresp_addr_ok,
                                   b3.dresp_addr_ok, b2.dresp_data_ok, b3.dresp_data_ok);
            end
            checks++;
            if (b2.dresp_data !== 32'h0 || b3.dresp_data !== 32'h0) begin
                errors++; $display("FAIL reset_data: got %h/%h expected 0", b2.dresp_data, b3.dresp_data);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        b3.dreq_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b2.dresp_addr_ok !== 1'b1) begin
            errors++; $display("FAIL reset_first_accept: got %b expected 1", b2.dresp_addr_ok);
        end
        @(posedge clk); #1;
        b2.dreq_valid = 1'b0;
        got = -1; k = 0;
        while (got < 0 && k < 8) begin
            @(negedge clk); k++;
            if (b2.dresp_data_ok === 1'b1) got = k;
        end
        checks++;
        if (got != 2) begin
            errors++; $display("FAIL reset_first_latency: got %0d expected 2", got);
        end
        m2[idx_of(32'h40)] = 32'hA5A5_0001;
    endtask

    task automatic test_word_rw;
        logic [31:0] rd;
        txn2(32'h0000_0010, 4'hF, 32'hDEAD_BEEF, rd);
        txn2(32'h0000_0010, 4'h0, 32'h0, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL word_read: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] rd;
        txn2(32'h20, 4'hF, 32'h1122_3344, rd);
        txn2(32'h20, 4'b0100, 32'h00AB_0000, rd);
        checks++;
        if (rd !== 32'h1122_3344) begin
            errors++; $display("FAIL strobe_old: got %h expected 11223344", rd);
        end
        txn2(32'h20, 4'h0, 32'h0, rd);
        checks++;
        if (rd !== 32'h11AB_3344) begin
            errors++; $display("FAIL strobe_merge: got %h expected 11ab3344", rd);
        end
    endtask

    task automatic test_alias;
        logic [31:0] rd;
        txn2(32'h0000_4008, 4'hF, 32'h5555_AAAA, rd);
        txn2(32'h0000_0008, 4'h0, 32'h0, rd);
        checks++;
        if (rd !== 32'h5555_AAAA) begin
            errors++; $display("FAIL alias_read: got %h expected 5555aaaa", rd);
        end
        txn2(32'h0000_000B, 4'h0, 32'h0, rd);
        checks++;
        if (rd !== 32'h5555_AAAA) begin
            errors++; $display("FAIL alias_lowbits: got %h expected 5555aaaa", rd);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a;
        int pool [6] = '{3, 17, 100, 511, 2048, 4095};
        for (int p = 0; p < 6; p++) txn2(32'(pool[p]) * 32'd4, 4'hF, $urandom, rd);
        for (int n = 0; n < 30; n++) begin
            a = ($urandom & 32'hFFFF_C000) | (32'(pool[$urandom % 6]) * 32'd4) | ($urandom % 4);
            txn2(a, 4'($urandom), $urandom, rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] qv[$];
        bit qk[$];
        bit acc, known;
        logic [31:0] exp;
        int i;
        bit sel = 1'b0;
        @(posedge clk); #1;
        b3.dreq_valid = 1'b1; b3.dreq_addr = 32'h100; b3.dreq_strobe = 4'hF;
        b3.dreq_data = $urandom; b3.dreq_size = 3'd2;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            checks++;
            if (b3.dresp_addr_ok !== ((c % 4) == 0)) begin
                errors++; $display("FAIL b2b_addr_ok cycle %0d: got %b expected %b", c,
                                   b3.dresp_addr_ok, (c % 4) == 0);
            end
            checks++;
            if (b3.dresp_data_ok !== ((c % 4) == 3)) begin
                errors++; $display("FAIL b2b_data_ok cycle %0d: got %b expected %b", c,
                                   b3.dresp_data_ok, (c % 4) == 3);
            end
            if (b3.dresp_data_ok === 1'b1 && qk.size() > 0) begin
                known = qk.pop_front();
                exp = qv.pop_front();
                if (known) begin
                    checks++;
                    if (b3.dresp_data !== exp) begin
                        errors++; $display("FAIL b2b_data cycle %0d: got %h expected %h", c, b3.dresp_data, exp);
                    end
                end
            end
            acc = (b3.dresp_addr_ok === 1'b1);
            if (acc) begin
                i = idx_of(b3.dreq_addr);
                qk.push_back(m3.exists(i));
                qv.push_back(m3.exists(i) ? m3[i] : 32'h0);
                m3[i] = b3.dreq_data;
            end
            @(posedge clk); #1;
            if (acc) begin
                sel = ~sel;
                b3.dreq_addr = sel ? 32'h204 : 32'h100;
                b3.dreq_data = $urandom;
            end
        end
        b3.dreq_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        txn2(32'h30, 4'hF, 32'h1234_5678, rd);
        @(posedge clk); #1;
        b2.dreq_valid = 1'b1; b2.dreq_addr = 32'h30; b2.dreq_strobe = 4'hF; b2.dreq_data = 32'h0;
        @(negedge clk);
        checks++;
        if (b2.dresp_addr_ok !== 1'b1) begin
            errors++; $display("FAIL midreset_accept: got %b expected 1", b2.dresp_addr_ok);
        end
        @(posedge clk); #1;
        b2.dreq_valid = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (b2.dresp_data_ok !== 1'b0) begin
                errors++; $display("FAIL midreset_data_ok cycle %0d: got %b expected 0", c, b2.dresp_data_ok);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        txn2(32'h30, 4'h0, 32'h0, rd);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL midreset_preserved: got %h expected 12345678", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_strobe();
        test_alias();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
